// File: rtl/updn_cnt_mod.sv
// Parametrised up/down event counter with parallel load, wrap/saturate mode
// and an optional one-shot RUN/DONE controller.
module updn_cnt_mod #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int WRAP      = 1,
    parameter int ONESHOT   = 0
) (
    input  logic             clk,
    input  logic             a_reset,
    input  logic             s_reset,
    input  logic             start,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped,
    output logic             done,
    output logic             state_dbg
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             done_q, done_d;
    logic             tc_w;

    // Terminal value depends on the direction currently requested.
    assign tc_w = up_dn ? (count_q == MAX_C) : (count_q == '0);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wrapped_d = 1'b0;
        done_d    = done_q;
        if (s_reset) begin
            state_d = S_RUN;
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            state_d = S_RUN;
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
            done_d  = 1'b0;
        end else if (start && (state_q == S_RUN)) begin
            if (!tc_w) begin
                count_d = up_dn ? (count_q + ONE_C) : (count_q - ONE_C);
            end else if (ONESHOT != 0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else if (WRAP != 0) begin
                count_d   = up_dn ? '0 : MAX_C;
                wrapped_d = 1'b1;
            end
            // Saturate mode: a terminal step simply holds the count.
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q   <= S_RUN;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            done_q    <= done_d;
        end
    end

    assign count     = count_q;
    assign tc        = tc_w;
    assign wrapped   = wrapped_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
